audio_addr_sequencer: RTL and testbench
=======================================

# audio_addr_sequencer

Parametrised, bounds-programmable address generator for sample-memory playback. It steps a read address between a runtime low and high bound, forward or backward, in one-shot, loop or ping-pong mode. It sits between the playback control FSM, which drives start, step and direction, and the memory read engine, which consumes `address`. Backward wrap and underflow at the low bound are fully defined.

## Interface
Parameters:
- `WIDTH`, 23: address width in bits.
- `CNT_W`, 8: width of the wrap counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  pulse. Latches `lo_addr`, `hi_addr`, `mode` and `forward`, then begins a run.
- `stop`  in  1  pulse. Aborts the run and returns to IDLE; `address` holds.
- `pause`  in  1  level. While high in RUN, `step` is ignored.
- `step`  in  1  pulse. Advance the address by one position.
- `forward`  in  1  direction: 1 = increment, 0 = decrement.
- `mode`  in  2  0 = ONESHOT, 1 = LOOP, 2 = PINGPONG, 3 = reserved (treated as ONESHOT).
- `lo_addr`  in  WIDTH  inclusive low bound.
- `hi_addr`  in  WIDTH  inclusive high bound.
- `address`  out  WIDTH  current address, registered.
- `busy`  out  1  high in RUN.
- `dir`  out  1  effective direction of the last or next step.
- `done`  out  1  one-cycle pulse when a ONESHOT run ends.
- `wrapped`  out  1  one-cycle pulse on each LOOP wrap or PINGPONG turn.
- `wrap_count`  out  CNT_W  saturating count of wraps and turns since `start`.
- `bound_err`  out  1  one-cycle pulse when `start` is rejected because `lo_addr > hi_addr`.

## Operation
States:
- IDLE: the only exit is `start` with valid bounds, to RUN.
- RUN:
  - exits to IDLE on `stop`, or on ONESHOT completion;
  - `start` in RUN restarts the run.

Start:
- Latches the bounds, mode and direction.
- Sets `address` to `lo` when forward, `hi` when backward.
- Sets `dir` from `forward` and clears `wrap_count`.
- If `lo > hi`: `bound_err` pulses, the state remains/returns IDLE, and `address` is unchanged.

Step (RUN, `pause` low):
- Direction source:
  - ONESHOT and LOOP sample `forward` on every step, so direction may reverse mid-run;
  - PINGPONG uses the internal `dir` and ignores `forward` after start.
- Interior address: `address ± 1`.
- Forward step at `hi`:
  - ONESHOT: `address` holds at `hi`, `done` pulses, go to IDLE;
  - LOOP: `address` ← `lo`, `wrapped` pulses;
  - PINGPONG: `dir` ← 0, `address` ← `hi-1`, `wrapped` pulses.
- Backward step at `lo`: mirror image of the forward case.
  - ONESHOT holds at `lo`.
  - LOOP sets `address` ← `hi`.
  - PINGPONG sets `dir` ← 1 and `address` ← `lo+1`.
- Single-address window (`lo == hi`): PINGPONG turn leaves `address` at `lo`; LOOP leaves it unchanged but still pulses `wrapped`.
- Arithmetic is unsigned WIDTH-bit. The bound compare happens before the add, so no modular overflow ever reaches `address`.
- `wrap_count` saturates at `2^CNT_W-1`.

Event priority, same cycle:
- `rst` > `start` > `stop` > `step`.
- `step` while paused or in IDLE is dropped; it is not queued.

## Timing
- Reset values: `address` = 0, state IDLE, `busy` = 0, `dir` = 1, and `done`, `wrapped`, `bound_err`, `wrap_count` all 0.
- Latency: `start` or `step` on edge N updates `address` at edge N+1, i.e. one cycle.
- `done`, `wrapped` and `bound_err` are registered. Each is high for exactly the one cycle after the triggering edge, aligned with the new `address`.
- `busy` falls in the same cycle `done` rises.
- `rst` mid-run: the next edge forces reset values. Pending pulses are cleared.
- Input bound changes during RUN have no effect until the next `start`.
- Back-to-back `step` on every cycle is supported at full rate.

## Structure
- Package `audio_seq_pkg`:
  - `mode_t` enum: ONESHOT, LOOP, PINGPONG;
  - `state_t` enum: IDLE, RUN;
  - a pure function `next_addr(addr, lo, hi, dir, mode)` returning the next address, the new direction and the wrap/end flags.
- No sub-module. A single always_ff, plus next-state logic that calls the package function.

## Test plan
- WIDTH=8, `lo`=3, `hi`=5, LOOP, forward, 4 steps -> `address` 3,4,5,3,4; `wrapped` pulses once; `wrap_count`=1.
- Same bounds, LOOP, backward from 5 -> 5,4,3,5; this confirms the backward wrap.
- PINGPONG, `lo`=0, `hi`=2, 6 steps -> 0,1,2,1,0,1,2; `dir` toggles at 2 and at 0; `wrap_count`=2.
- ONESHOT, `lo`=10, `hi`=11, forward, 3 steps -> 10,11, then `done` pulse with `address` held at 11 and `busy` low; the third step is ignored.
- `start` with `lo`=9, `hi`=4 -> `bound_err` pulse, `busy` stays 0.
- Simultaneous `start`+`step`, `pause` dropping steps, and `rst` mid-run at `address`=0x42 -> `address`=0, IDLE, no pulses.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// ---------------------------------------------------------------------------
// audio_seq_pkg
//
// Shared types and the address-stepping function for audio_addr_sequencer.
//
//   mode_t      playback mode (ONESHOT / LOOP / PINGPONG)
//   state_t     sequencer state (IDLE / RUN)
//   step_t      result of one step: next address, new direction, flags
//   decode_mode maps the raw 2-bit mode input; the reserved code runs as ONESHOT
//   next_addr   pure next-address function, evaluated on the widest
//               supported address (ADDR_MAX_W) and narrowed by the caller
// ---------------------------------------------------------------------------
package audio_seq_pkg;

    // Upper limit on the WIDTH parameter of the sequencer (WIDTH < ADDR_MAX_W).
    localparam int unsigned ADDR_MAX_W = 64;

    typedef logic [ADDR_MAX_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ONESHOT  = 2'd0,
        LOOP     = 2'd1,
        PINGPONG = 2'd2
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        addr_t addr;     // address after the step
        logic  dir;      // direction after the step (1 = up)
        logic  wrapped;  // LOOP wrap or PINGPONG turn happened
        logic  ended;    // ONESHOT run reached its final bound
    } step_t;

    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return LOOP;
            2'd2:    return PINGPONG;
            default: return ONESHOT;
        endcase
    endfunction

    // The bound test is done before any add/subtract, so the result is
    // always inside [lo, hi] and never a modular wrap of the arithmetic.
    // Single-address windows (lo == hi) turn in place for PINGPONG.
    function automatic step_t next_addr(input addr_t addr,
                                        input addr_t lo,
                                        input addr_t hi,
                                        input logic  dir,
                                        input mode_t mode);
        step_t r;
        r.addr    = addr;
        r.dir     = dir;
        r.wrapped = 1'b0;
        r.ended   = 1'b0;
        if (dir) begin
            if (addr >= hi) begin
                case (mode)
                    LOOP: begin
                        r.addr    = lo;
                        r.wrapped = 1'b1;
                    end
                    PINGPONG: begin
                        r.dir     = 1'b0;
                        r.addr    = (hi > lo) ? hi - addr_t'(1) : lo;
                        r.wrapped = 1'b1;
                    end
                    default: r.ended = 1'b1;
                endcase
            end else begin
                r.addr = addr + addr_t'(1);
            end
        end else begin
            if (addr <= lo) begin
                case (mode)
                    LOOP: begin
                        r.addr    = hi;
                        r.wrapped = 1'b1;
                    end
                    PINGPONG: begin
                        r.dir     = 1'b1;
                        r.addr    = (hi > lo) ? lo + addr_t'(1) : lo;
                        r.wrapped = 1'b1;
                    end
                    default: r.ended = 1'b1;
                endcase
            end else begin
                r.addr = addr - addr_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_addr_sequencer.sv
// ---------------------------------------------------------------------------
// audio_addr_sequencer
//
// Bounds-programmable read-address generator for sample playback. Steps an
// address between latched low/high bounds, up or down, in ONESHOT, LOOP or
// PINGPONG mode.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   start        pulse: latch lo_addr/hi_addr/mode/forward and begin a run
//   stop         pulse: abort run, address holds
//   pause        level: steps ignored while high
//   step         pulse: advance one position
//   forward      direction request (1 = up); sampled per step except PINGPONG
//   mode         0 ONESHOT, 1 LOOP, 2 PINGPONG, 3 runs as ONESHOT
//   lo_addr      inclusive low bound
//   hi_addr      inclusive high bound
//   address      current registered address
//   busy         high while running
//   dir          effective direction of the last/next step
//   done         one-cycle pulse when a ONESHOT run ends
//   wrapped      one-cycle pulse on each LOOP wrap / PINGPONG turn
//   wrap_count   saturating wrap/turn count since start
//   bound_err    one-cycle pulse when start is rejected (lo_addr > hi_addr)
//
// Same-cycle priority: rst > start > stop > step.
// ---------------------------------------------------------------------------
module audio_addr_sequencer
    import audio_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             step,
    input  logic             forward,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo_addr,
    input  logic [WIDTH-1:0] hi_addr,
    output logic [WIDTH-1:0] address,
    output logic             busy,
    output logic             dir,
    output logic             done,
    output logic             wrapped,
    output logic [CNT_W-1:0] wrap_count,
    output logic             bound_err
);

    state_t           state_q,   state_d;
    mode_t            mode_q,    mode_d;
    logic [WIDTH-1:0] addr_q,    addr_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic             dir_q,     dir_d;
    logic [CNT_W-1:0] wcnt_q,    wcnt_d;
    logic             done_q,    done_d;
    logic             wrapped_q, wrapped_d;
    logic             berr_q,    berr_d;

    step_t            step_res;
    logic             step_dir;
    logic             unused_step_hi;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= ONESHOT;
            addr_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dir_q     <= 1'b1;
            wcnt_q    <= '0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dir_q     <= dir_d;
            wcnt_q    <= wcnt_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
            berr_q    <= berr_d;
        end
    end

    // ------------------------------------------------------------------
    // Step evaluation: PINGPONG follows its own direction, the other
    // modes take the live forward input on every step.
    // ------------------------------------------------------------------
    always_comb begin
        step_dir = (mode_q == PINGPONG) ? dir_q : forward;
        step_res = next_addr(addr_t'(addr_q), addr_t'(lo_q), addr_t'(hi_q),
                             step_dir, mode_q);
    end

    // Upper bits are always zero because the inputs are zero-extended.
    assign unused_step_hi = ^step_res.addr[ADDR_MAX_W-1:WIDTH];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dir_d     = dir_q;
        wcnt_d    = wcnt_q;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        berr_d    = 1'b0;

        if (start) begin
            if (lo_addr > hi_addr) begin
                // Rejected start: flag it and drop out of any active run,
                // leaving address/direction/bounds untouched.
                berr_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
                lo_d    = lo_addr;
                hi_d    = hi_addr;
                mode_d  = decode_mode(mode);
                dir_d   = forward;
                addr_d  = forward ? lo_addr : hi_addr;
                wcnt_d  = '0;
            end
        end else if (stop) begin
            state_d = IDLE;
        end else if ((state_q == RUN) && step && !pause) begin
            addr_d    = step_res.addr[WIDTH-1:0];
            dir_d     = step_res.dir;
            wrapped_d = step_res.wrapped;
            done_d    = step_res.ended;
            if (step_res.ended) begin
                state_d = IDLE;
            end
            if (step_res.wrapped && (wcnt_q != '1)) begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    always_comb begin
        address    = addr_q;
        busy       = (state_q == RUN);
        dir        = dir_q;
        done       = done_q;
        wrapped    = wrapped_q;
        wrap_count = wcnt_q;
        bound_err  = berr_q;
    end

endmodule

// File: tb/tb_audio_addr_sequencer.sv
module tb_audio_addr_sequencer;

    localparam int W = 8;
    localparam int C = 3;

    localparam logic [1:0] M_ONE  = 2'd0;
    localparam logic [1:0] M_LOOP = 2'd1;
    localparam logic [1:0] M_PP   = 2'd2;
    localparam logic [1:0] M_RSV  = 2'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0, forward = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] lo_addr = '0, hi_addr = '0;
    logic [W-1:0] address;
    logic         busy, dir, done, wrapped, bound_err;
    logic [C-1:0] wrap_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    audio_addr_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .step       (step),
        .forward    (forward),
        .mode       (mode),
        .lo_addr    (lo_addr),
        .hi_addr    (hi_addr),
        .address    (address),
        .busy       (busy),
        .dir        (dir),
        .done       (done),
        .wrapped    (wrapped),
        .wrap_count (wrap_count),
        .bound_err  (bound_err)
    );

    typedef struct packed {
        logic         r, st, sp, stp, pau, fwd;
        logic [1:0]   m;
        logic [W-1:0] lo, hi;
    } stim_t;

    // Packed as addr | busy | dir | done | wrapped | wrap_count | bound_err
    typedef struct packed {
        logic [W-1:0] addr;
        logic         busy, dir, done, wr;
        logic [C-1:0] cnt;
        logic         berr;
    } obs_t;

    obs_t sb[$];

    function automatic stim_t S(input logic r, st, sp, stp, pau, fwd,
                                input logic [1:0] m, input logic [W-1:0] lo, hi);
        stim_t s;
        s.r = r; s.st = st; s.sp = sp; s.stp = stp; s.pau = pau; s.fwd = fwd;
        s.m = m; s.lo = lo; s.hi = hi;
        return s;
    endfunction

    function automatic obs_t X(input logic [W-1:0] a, input logic b, d, dn, w,
                               input logic [C-1:0] c, input logic e);
        obs_t o;
        o.addr = a; o.busy = b; o.dir = d; o.done = dn; o.wr = w; o.cnt = c; o.berr = e;
        return o;
    endfunction

    function automatic obs_t observe();
        return X(address, busy, dir, done, wrapped, wrap_count, bound_err);
    endfunction

    // Apply one cycle of inputs across a rising edge, then settle.
    task automatic drive(input stim_t s);
        rst = s.r; start = s.st; stop = s.sp; step = s.stp; pause = s.pau;
        forward = s.fwd; mode = s.m; lo_addr = s.lo; hi_addr = s.hi;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(1,0,0,0,0,0,M_ONE,0,0));    x.push_back(X(0,0,1,0,0,0,0));
        s.push_back(S(1,1,0,1,0,1,M_LOOP,3,5));   x.push_back(X(0,0,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_ONE,0,0));    x.push_back(X(0,0,1,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_loop_fwd();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_LOOP,3,5));   x.push_back(X(3,1,1,0,0,0,0));
        // bound/mode inputs change mid-run and must be ignored
        s.push_back(S(0,0,0,1,0,1,M_PP,0,255));   x.push_back(X(4,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,0,255));   x.push_back(X(5,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,0,255));   x.push_back(X(3,1,1,0,1,1,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,0,255));   x.push_back(X(4,1,1,0,0,1,0));
        s.push_back(S(0,0,1,0,0,1,M_ONE,0,0));    x.push_back(X(4,0,1,0,0,1,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL loop_fwd[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_loop_bwd();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,0,M_LOOP,3,5));   x.push_back(X(5,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,3,5));   x.push_back(X(4,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,3,5));   x.push_back(X(3,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,3,5));   x.push_back(X(5,1,0,0,1,1,0));
        // direction reversal mid-run: forward at hi wraps to lo
        s.push_back(S(0,0,0,1,0,1,M_LOOP,3,5));   x.push_back(X(3,1,1,0,1,2,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,3,5));   x.push_back(X(5,1,0,0,1,3,0));
        // stop beats step
        s.push_back(S(0,0,1,1,0,0,M_LOOP,3,5));   x.push_back(X(5,0,0,0,0,3,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL loop_bwd[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_pingpong();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_PP,0,2));     x.push_back(X(0,1,1,0,0,0,0));
        // forward held low: PINGPONG must ignore it after start
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(1,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(2,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(1,1,0,0,1,1,0));
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(0,1,0,0,0,1,0));
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(1,1,1,0,1,2,0));
        s.push_back(S(0,0,0,1,0,0,M_PP,0,2));     x.push_back(X(2,1,1,0,0,2,0));
        s.push_back(S(0,0,1,0,0,0,M_PP,0,2));     x.push_back(X(2,0,1,0,0,2,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pingpong[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_oneshot();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_ONE,10,11));  x.push_back(X(10,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_ONE,10,11));  x.push_back(X(11,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_ONE,10,11));  x.push_back(X(11,0,1,1,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_ONE,10,11));  x.push_back(X(11,0,1,0,0,0,0));
        // reserved mode runs as ONESHOT; backward end holds at lo
        s.push_back(S(0,1,0,0,0,0,M_RSV,0,1));    x.push_back(X(1,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_RSV,0,1));    x.push_back(X(0,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_RSV,0,1));    x.push_back(X(0,0,0,1,0,0,0));
        s.push_back(S(0,0,0,0,0,0,M_RSV,0,1));    x.push_back(X(0,0,0,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL oneshot[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_bound_err();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_LOOP,9,4));   x.push_back(X(0,0,0,0,0,0,1));
        s.push_back(S(0,0,0,0,0,1,M_LOOP,9,4));   x.push_back(X(0,0,0,0,0,0,0));
        s.push_back(S(0,1,0,0,0,1,M_LOOP,3,5));   x.push_back(X(3,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,3,5));   x.push_back(X(4,1,1,0,0,0,0));
        // rejected start in RUN returns to IDLE, address held, beats step
        s.push_back(S(0,1,0,1,0,0,M_LOOP,9,4));   x.push_back(X(4,0,1,0,0,0,1));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,3,5));   x.push_back(X(4,0,1,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL bound_err[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_start_step_pause();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_LOOP,20,30)); x.push_back(X(20,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,20,30)); x.push_back(X(21,1,1,0,0,0,0));
        // start beats stop and step in the same cycle
        s.push_back(S(0,1,1,1,0,0,M_LOOP,40,50)); x.push_back(X(50,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,1,0,M_LOOP,40,50)); x.push_back(X(50,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,1,0,M_LOOP,40,50)); x.push_back(X(50,1,0,0,0,0,0));
        s.push_back(S(0,0,0,0,0,0,M_LOOP,40,50)); x.push_back(X(50,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,40,50)); x.push_back(X(49,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,40,50)); x.push_back(X(48,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,40,50)); x.push_back(X(47,1,0,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL start_step_pause[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_single_window();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_LOOP,7,7));   x.push_back(X(7,1,1,0,0,0,0));
        for (int k = 1; k <= 9; k++) begin
            s.push_back(S(0,0,0,1,0,1,M_LOOP,7,7));
            x.push_back(X(7,1,1,0,1,(k > 7) ? 3'd7 : 3'(k),0));
        end
        s.push_back(S(0,1,0,0,0,1,M_PP,7,7));     x.push_back(X(7,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,7,7));     x.push_back(X(7,1,0,0,1,1,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,7,7));     x.push_back(X(7,1,1,0,1,2,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single_window[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_edges();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        // top of address space: wrap goes to lo, never to 0
        s.push_back(S(0,1,0,0,0,1,M_LOOP,8'hFE,8'hFF)); x.push_back(X(8'hFE,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,8'hFE,8'hFF)); x.push_back(X(8'hFF,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,8'hFE,8'hFF)); x.push_back(X(8'hFE,1,1,0,1,1,0));
        // bottom of address space: backward wrap goes to hi, no underflow
        s.push_back(S(0,1,0,0,0,0,M_LOOP,0,3));   x.push_back(X(3,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,0,3));   x.push_back(X(2,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,0,3));   x.push_back(X(1,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,0,3));   x.push_back(X(0,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,0,M_LOOP,0,3));   x.push_back(X(3,1,0,0,1,1,0));
        // PINGPONG started backward turns at lo to lo+1
        s.push_back(S(0,1,0,0,0,0,M_PP,0,1));     x.push_back(X(1,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,0,1));     x.push_back(X(0,1,0,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_PP,0,1));     x.push_back(X(1,1,1,0,1,1,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL edges[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    task automatic test_rst_mid();
        stim_t s[$]; obs_t x[$]; obs_t got, e;
        s.push_back(S(0,1,0,0,0,1,M_LOOP,8'h40,8'h42)); x.push_back(X(8'h40,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,8'h40,8'h42)); x.push_back(X(8'h41,1,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,8'h40,8'h42)); x.push_back(X(8'h42,1,1,0,0,0,0));
        // reset on the edge that would otherwise wrap: no pulse survives
        s.push_back(S(1,0,0,1,0,1,M_LOOP,8'h40,8'h42)); x.push_back(X(0,0,1,0,0,0,0));
        s.push_back(S(0,0,0,1,0,1,M_LOOP,8'h40,8'h42)); x.push_back(X(0,0,1,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(x[i]); drive(s[i]); e = sb.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rst_mid[%0d] actual=%h required=%h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loop_fwd();
        test_loop_bwd();
        test_pingpong();
        test_oneshot();
        test_bound_err();
        test_start_step_pause();
        test_single_window();
        test_edges();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
